mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs, performs the data-memory load/store, and resolves the branch decision. Registers everything write-back needs into the MEM/WB boundary. Supports stall (hold) and flush (bubble) and reports misaligned accesses.

## Interface
Parameters:
- ADDR_W, 8, word-address width; memory depth = 2^ADDR_W 32-bit words

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- EXtoMEM_zero  in  1  ALU zero flag
- EXtoMEM_ALUresult  in  32  byte address (load/store) or ALU result
- EXtoMEM_WriteData  in  32  store data (forwarded rt value)
- EXtoMEM_Branch_Addr  in  32  branch target
- EXtoMEM_RegDest  in  5  destination register number
- MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite  in  1 each  control bits
- stall  in  1  hold MEM/WB register, suppress memory write
- flush  in  1  load bubble into MEM/WB, suppress memory write
- PCSrc  out  1  branch taken (combinational)
- MEM_Branch_Target  out  32  EXtoMEM_Branch_Addr passed through (combinational)
- MEMtoWB_ReadData  out  32  loaded word
- MEMtoWB_ALUresult  out  32  registered ALU result
- MEMtoWB_RegDest  out  5  registered destination
- WB_MemtoReg, WB_RegWrite  out  1 each  registered WB controls
- WB_fault  out  1  registered one-cycle misalignment flag
- fault_sticky  out  1  set on any fault, cleared only by reset

## Operation
- PCSrc = MEM_Branch & EXtoMEM_zero; no dependence on stall/flush.
- Word index = EXtoMEM_ALUresult[ADDR_W+1:2]; upper bits ignored (address wraps modulo depth).
- misaligned = (MEM_MemRead | MEM_MemWrite) & (EXtoMEM_ALUresult[1:0] != 0).
- we = MEM_MemWrite & ~misaligned & ~stall & ~flush; write happens at the rising edge ending the MEM cycle.
- Load: synchronous read at the same edge; the data lands directly in MEMtoWB_ReadData.
- Register update priority per edge: flush > stall > normal.
  - flush: WB_RegWrite=0, WB_MemtoReg=0, WB_fault=0; data fields hold.
  - stall: all MEM/WB outputs hold, including ReadData; no memory write.
  - normal: all fields load. WB_fault=misaligned. WB_RegWrite = MEM_RegWrite & ~misaligned. ReadData = memory word, or 0 when the access is misaligned or not a load.
- fault_sticky sets on the edge where WB_fault loads 1.
- Memory contents are not reset; undefined until written.

## Timing
- Reset (rst=0, async): all MEM/WB outputs 0, fault_sticky 0; memory untouched. Release is synchronous to the next edge with no special sequencing.
- Load latency: address valid in cycle N; MEMtoWB_ReadData valid in cycle N+1.
- Store: visible to a load presented in cycle N+1.
- Back-to-back store then load to the same word: load returns the new data. There is never a same-cycle read/write conflict, since one instruction occupies MEM per cycle.
- Reset asserted mid-store: write may or may not occur; the bench must not check it.
- stall and flush together: flush behaviour.

## Structure
- Shared package mips_pkg: ADDR_W default, WORD_W=32, REG_W=5, bubble constant for WB control bits.
- Sub-module data_mem: single-port synchronous RAM (clk, we, addr, wdata, rdata), no reset, read-before/after irrelevant as only one access occurs per cycle.
- The top level holds PCSrc logic, misalignment check, MEM/WB register and sticky flag.

## Test plan
- Store then load: SW 0xDEADBEEF at addr 0x10, next cycle LW 0x10 -> MEMtoWB_ReadData=0xDEADBEEF one cycle later, WB_MemtoReg=1, WB_RegWrite=1.
- Branch: MEM_Branch=1 with zero=1 -> PCSrc=1, MEM_Branch_Target=0x00400020 same cycle; zero=0 -> PCSrc=0.
- Misaligned: SW at 0x12 -> no write (LW 0x10 still returns the old value), WB_fault=1 for one cycle, WB_RegWrite=0, fault_sticky=1 until reset.
- Stall: SW 0x55 to 0x20 with stall=1 -> memory unchanged, MEM/WB outputs hold prior values; deassert -> write occurs once.
- Flush: R-type with RegWrite=1 and flush=1 -> WB_RegWrite=0, WB_MemtoReg=0; a simultaneous store is suppressed.
- Reset mid-run: drop rst asynchronously between edges -> all outputs 0 immediately, fault_sticky=0; address 0x400 wraps to word index 0 when ADDR_W=8.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and write-back control encodings for the MIPS pipeline stages.
package mips_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_W      = 5;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  // Control bits of an inserted bubble: nothing reaches the register file.
  localparam wb_ctrl_t WB_BUBBLE = '{mem_to_reg: 1'b0, reg_write: 1'b0};

  typedef enum logic [1:0] {
    UpdNormal,
    UpdStall,
    UpdFlush
  } upd_mode_e;

  // Flush dominates stall when both are raised.
  function automatic upd_mode_e upd_mode(input logic flush, input logic stall);
    upd_mode_e mode;
    if (flush) begin
      mode = UpdFlush;
    end else if (stall) begin
      mode = UpdStall;
    end else begin
      mode = UpdNormal;
    end
    return mode;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Single-port data RAM. Writes commit on the rising edge; the read port is the
// array lookup, captured by the MEM/WB register in the same edge.
module data_mem
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [WORD_W-1:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data memory access, branch decision,
// misalignment detection and the MEM/WB pipeline register with stall/flush.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXtoMEM_zero,
  input  logic [WORD_W-1:0] EXtoMEM_ALUresult,
  input  logic [WORD_W-1:0] EXtoMEM_WriteData,
  input  logic [WORD_W-1:0] EXtoMEM_Branch_Addr,
  input  logic [REG_W-1:0]  EXtoMEM_RegDest,
  input  logic              MEM_Branch,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_RegWrite,
  input  logic              stall,
  input  logic              flush,
  output logic              PCSrc,
  output logic [WORD_W-1:0] MEM_Branch_Target,
  output logic [WORD_W-1:0] MEMtoWB_ReadData,
  output logic [WORD_W-1:0] MEMtoWB_ALUresult,
  output logic [REG_W-1:0]  MEMtoWB_RegDest,
  output logic              WB_MemtoReg,
  output logic              WB_RegWrite,
  output logic              WB_fault,
  output logic              fault_sticky
);

  logic [ADDR_W-1:0] w_word_idx;
  logic [WORD_W-1:0] w_mem_rdata;
  logic [WORD_W-1:0] w_load_data;
  logic              w_misaligned;
  logic              w_we;
  logic              w_unused_addr;
  upd_mode_e         w_mode;

  logic [WORD_W-1:0] r_read_data;
  logic [WORD_W-1:0] r_alu_result;
  logic [REG_W-1:0]  r_reg_dest;
  wb_ctrl_t          r_wb_ctrl;
  logic              r_wb_fault;
  logic              r_fault_sticky;

  assign PCSrc             = MEM_Branch & EXtoMEM_zero;
  assign MEM_Branch_Target = EXtoMEM_Branch_Addr;

  // Upper address bits are dropped, so accesses wrap modulo the memory depth.
  assign w_word_idx    = EXtoMEM_ALUresult[ADDR_W+1:2];
  assign w_unused_addr = ^EXtoMEM_ALUresult[WORD_W-1:ADDR_W+2];

  assign w_misaligned = (MEM_MemRead | MEM_MemWrite) & (EXtoMEM_ALUresult[1:0] != 2'b00);
  assign w_mode       = upd_mode(flush, stall);
  assign w_we         = MEM_MemWrite & ~w_misaligned & (w_mode == UpdNormal);
  assign w_load_data  = (MEM_MemRead & ~w_misaligned) ? w_mem_rdata : '0;

  data_mem #(
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_word_idx),
    .wdata (EXtoMEM_WriteData),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_reg_dest   <= '0;
      r_wb_ctrl    <= WB_BUBBLE;
      r_wb_fault   <= 1'b0;
    end else begin
      unique case (w_mode)
        UpdFlush: begin
          // Data fields keep their last values; only the controls are killed.
          r_wb_ctrl  <= WB_BUBBLE;
          r_wb_fault <= 1'b0;
        end
        UpdStall: begin
        end
        UpdNormal: begin
          r_read_data          <= w_load_data;
          r_alu_result         <= EXtoMEM_ALUresult;
          r_reg_dest           <= EXtoMEM_RegDest;
          r_wb_ctrl.mem_to_reg <= MEM_MemtoReg;
          r_wb_ctrl.reg_write  <= MEM_RegWrite & ~w_misaligned;
          r_wb_fault           <= w_misaligned;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault_sticky <= 1'b0;
    end else if ((w_mode == UpdNormal) && w_misaligned) begin
      r_fault_sticky <= 1'b1;
    end
  end

  assign MEMtoWB_ReadData  = r_read_data;
  assign MEMtoWB_ALUresult = r_alu_result;
  assign MEMtoWB_RegDest   = r_reg_dest;
  assign WB_MemtoReg       = r_wb_ctrl.mem_to_reg;
  assign WB_RegWrite       = r_wb_ctrl.reg_write;
  assign WB_fault          = r_wb_fault;
  assign fault_sticky      = r_fault_sticky;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a queue-based scoreboard of MEM/WB results.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        EXtoMEM_zero;
  logic [31:0] EXtoMEM_ALUresult;
  logic [31:0] EXtoMEM_WriteData;
  logic [31:0] EXtoMEM_Branch_Addr;
  logic [4:0]  EXtoMEM_RegDest;
  logic        MEM_Branch;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic        MEM_MemtoReg;
  logic        MEM_RegWrite;
  logic        stall;
  logic        flush;
  logic        PCSrc;
  logic [31:0] MEM_Branch_Target;
  logic [31:0] MEMtoWB_ReadData;
  logic [31:0] MEMtoWB_ALUresult;
  logic [4:0]  MEMtoWB_RegDest;
  logic        WB_MemtoReg;
  logic        WB_RegWrite;
  logic        WB_fault;
  logic        fault_sticky;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        mtr;
    logic        rw;
    logic        fault;
  } wb_t;

  wb_t         sb_q[$];
  wb_t         exp_prev;
  logic        sticky_exp;
  logic [31:0] ref_mem [bit [7:0]];
  logic [31:0] tgt;
  int          checks;
  int          errors;

  mem_wb_stage #(
    .ADDR_W (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EXtoMEM_zero        (EXtoMEM_zero),
    .EXtoMEM_ALUresult   (EXtoMEM_ALUresult),
    .EXtoMEM_WriteData   (EXtoMEM_WriteData),
    .EXtoMEM_Branch_Addr (EXtoMEM_Branch_Addr),
    .EXtoMEM_RegDest     (EXtoMEM_RegDest),
    .MEM_Branch          (MEM_Branch),
    .MEM_MemRead         (MEM_MemRead),
    .MEM_MemWrite        (MEM_MemWrite),
    .MEM_MemtoReg        (MEM_MemtoReg),
    .MEM_RegWrite        (MEM_RegWrite),
    .stall               (stall),
    .flush               (flush),
    .PCSrc               (PCSrc),
    .MEM_Branch_Target   (MEM_Branch_Target),
    .MEMtoWB_ReadData    (MEMtoWB_ReadData),
    .MEMtoWB_ALUresult   (MEMtoWB_ALUresult),
    .MEMtoWB_RegDest     (MEMtoWB_RegDest),
    .WB_MemtoReg         (WB_MemtoReg),
    .WB_RegWrite         (WB_RegWrite),
    .WB_fault            (WB_fault),
    .fault_sticky        (fault_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string nm, input wb_t e);
    chk({nm, ":ReadData"}, MEMtoWB_ReadData, e.rd);
    chk({nm, ":ALUresult"}, MEMtoWB_ALUresult, e.alu);
    chk({nm, ":RegDest"}, 32'(MEMtoWB_RegDest), 32'(e.dest));
    chk({nm, ":MemtoReg"}, 32'(WB_MemtoReg), 32'(e.mtr));
    chk({nm, ":RegWrite"}, 32'(WB_RegWrite), 32'(e.rw));
    chk({nm, ":fault"}, 32'(WB_fault), 32'(e.fault));
    chk({nm, ":sticky"}, 32'(fault_sticky), 32'(sticky_exp));
  endtask

  task automatic drive_nop();
    EXtoMEM_zero        = 1'b0;
    EXtoMEM_ALUresult   = 32'h0;
    EXtoMEM_WriteData   = 32'h0;
    EXtoMEM_Branch_Addr = 32'h0;
    EXtoMEM_RegDest     = 5'd0;
    MEM_Branch          = 1'b0;
    MEM_MemRead         = 1'b0;
    MEM_MemWrite        = 1'b0;
    MEM_MemtoReg        = 1'b0;
    MEM_RegWrite        = 1'b0;
    stall               = 1'b0;
    flush               = 1'b0;
  endtask

  // Drives one instruction for one MEM cycle, predicts its MEM/WB result.
  task automatic issue(input string nm, input logic [31:0] alu, input logic [31:0] wdata,
                       input logic [4:0] dest, input logic br, input logic zr,
                       input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic stl, input logic fl);
    wb_t        e;
    logic       mis;
    logic [7:0] idx;
    EXtoMEM_ALUresult   = alu;
    EXtoMEM_WriteData   = wdata;
    EXtoMEM_RegDest     = dest;
    EXtoMEM_Branch_Addr = tgt;
    EXtoMEM_zero        = zr;
    MEM_Branch          = br;
    MEM_MemRead         = mr;
    MEM_MemWrite        = mw;
    MEM_MemtoReg        = m2r;
    MEM_RegWrite        = rw;
    stall               = stl;
    flush               = fl;
    mis = (mr | mw) && (alu[1:0] != 2'b00);
    idx = alu[9:2];
    if (fl) begin
      e       = exp_prev;
      e.mtr   = 1'b0;
      e.rw    = 1'b0;
      e.fault = 1'b0;
    end else if (stl) begin
      e = exp_prev;
    end else begin
      e.rd    = (mr && !mis) ? ref_mem[idx] : 32'h0;
      e.alu   = alu;
      e.dest  = dest;
      e.mtr   = m2r;
      e.rw    = rw & ~mis;
      e.fault = mis;
      if (mis) sticky_exp = 1'b1;
    end
    if (mw && !mis && !stl && !fl) ref_mem[idx] = wdata;
    exp_prev = e;
    sb_q.push_back(e);
    #1;
    chk({nm, ":PCSrc"}, 32'(PCSrc), 32'(br & zr));
    chk({nm, ":BrTarget"}, MEM_Branch_Target, tgt);
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() == 1) else begin
      errors++;
      $error("FAIL %s:scoreboard observed=%0d expected=1", nm, sb_q.size());
    end
    e = sb_q.pop_front();
    chk_wb(nm, e);
  endtask

  task automatic sw(input string nm, input logic [31:0] a, input logic [31:0] d,
                    input logic stl, input logic fl);
    issue(nm, a, d, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, stl, fl);
  endtask

  task automatic lw(input string nm, input logic [31:0] a, input logic [4:0] dest);
    issue(nm, a, 32'h0, dest, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rtype(input string nm, input logic [31:0] res, input logic [4:0] dest,
                       input logic stl, input logic fl);
    issue(nm, res, 32'h0, dest, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, stl, fl);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    sticky_exp = 1'b0;
    exp_prev   = '0;
    tgt        = 32'h0000_1000;
    drive_nop();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_wb("reset", exp_prev);
    @(negedge clk);
    rst = 1'b1;

    sw("sw_10", 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    lw("lw_10", 32'h10, 5'd8);

    tgt = 32'h0040_0020;
    issue("br_taken", 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("br_not", 32'h4, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tgt = 32'h0000_2000;

    sw("sw_mis_12", 32'h12, 32'h1234_5678, 1'b0, 1'b0);
    issue("lw_mis_11", 32'h11, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lw("lw_10_old", 32'h10, 5'd10);

    sw("sw_20", 32'h20, 32'h0000_0011, 1'b0, 1'b0);
    sw("sw_20_stall", 32'h20, 32'h0000_0055, 1'b1, 1'b0);
    lw("lw_20_pre", 32'h20, 5'd11);
    sw("sw_20_go", 32'h20, 32'h0000_0055, 1'b0, 1'b0);
    lw("lw_20_post", 32'h20, 5'd12);

    sw("sw_30", 32'h30, 32'hA5A5_A5A5, 1'b0, 1'b0);
    rtype("r_flush", 32'h77, 5'd3, 1'b0, 1'b1);
    sw("sw_30_flush", 32'h30, 32'h0000_0BAD, 1'b0, 1'b1);
    lw("lw_30", 32'h30, 5'd13);
    rtype("r_stall_flush", 32'h99, 5'd4, 1'b1, 1'b1);
    rtype("r_plain", 32'h1234, 5'd5, 1'b0, 1'b0);
    rtype("r_stall", 32'h5678, 5'd6, 1'b1, 1'b0);

    drive_nop();
    #2 rst = 1'b0;
    #1;
    exp_prev   = '0;
    sticky_exp = 1'b0;
    chk_wb("reset_mid", exp_prev);
    @(negedge clk);
    rst = 1'b1;

    sw("sw_400", 32'h400, 32'hCAFE_F00D, 1'b0, 1'b0);
    lw("lw_0_wrap", 32'h0, 5'd14);
    sw("sw_0", 32'h0, 32'h0BAD_CAFE, 1'b0, 1'b0);
    lw("lw_400_wrap", 32'h400, 5'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
